// File: rtl/mac_psum_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// mac_psum_accumulator_pkg : default widths shared across the conv datapath
// Revision: 1.0
// ============================================================================
package mac_psum_accumulator_pkg;

  localparam int c_data_width      = 8;
  localparam int c_psum_width      = 20;
  localparam int c_fifo_depth      = 4;
  localparam int c_fifo_addr_width = 2;

endpackage
`default_nettype wire

// File: rtl/mac_psum_accumulator_psum_fifo.sv
`default_nettype none
// ============================================================================
// psum_fifo : synchronous FIFO for finished partial sums, sticky overflow flag
// Revision: 1.0
// ============================================================================
module psum_fifo #(
  parameter int WIDTH      = 21,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_overflow
);

  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_cnt_one  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   c_cnt_full = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == c_cnt_full);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst && w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - c_cnt_one;
      end
      if (i_push && !w_do_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/mac_psum_accumulator.sv
`default_nettype none
// ============================================================================
// mac_psum_accumulator : issue/multiply/accumulate pipeline feeding a psum FIFO
// Revision: 1.0
// ============================================================================
module mac_psum_accumulator
  import mac_psum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH      = c_data_width,
  parameter int PSUM_WIDTH      = c_psum_width,
  parameter int FIFO_DEPTH      = c_fifo_depth,
  parameter int FIFO_ADDR_WIDTH = c_fifo_addr_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  clr_addr,
  input  logic                  read_data,
  input  logic                  co_pipe,
  input  logic                  at_end_data,
  input  logic [DATA_WIDTH-1:0] ifmap_data,
  input  logic [DATA_WIDTH-1:0] filter_data,
  input  logic                  psum_ready,
  output logic [PSUM_WIDTH-1:0] psum_out,
  output logic                  psum_valid,
  output logic                  psum_last,
  output logic                  stall_req,
  output logic                  err_overflow
);

  localparam logic [FIFO_ADDR_WIDTH+1:0] c_credit_limit = (FIFO_ADDR_WIDTH+2)'(FIFO_DEPTH - 1);

  logic r_v1, r_l1, r_e1;
  logic r_v2, r_l2, r_e2;
  logic [PSUM_WIDTH-1:0] r_prod;
  logic [PSUM_WIDTH-1:0] r_acc;
  logic                  r_first;

  logic signed [PSUM_WIDTH-1:0] w_mul_a;
  logic signed [PSUM_WIDTH-1:0] w_mul_b;
  logic signed [PSUM_WIDTH-1:0] w_prod;
  logic [PSUM_WIDTH-1:0]        w_sum;
  logic                         w_push;
  logic [PSUM_WIDTH:0]          w_fifo_out;
  logic [FIFO_ADDR_WIDTH:0]     w_count;
  logic                         w_empty;
  logic [FIFO_ADDR_WIDTH+1:0]   w_credit;

  // Operands widened first so the low PSUM_WIDTH bits of the product are exact
  assign w_mul_a = PSUM_WIDTH'($signed(ifmap_data));
  assign w_mul_b = PSUM_WIDTH'($signed(filter_data));
  assign w_prod  = w_mul_a * w_mul_b;
  assign w_sum   = (r_first ? '0 : r_acc) + r_prod;
  assign w_push  = r_v2 & r_l2 & ~stall & ~clr_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_l1    <= 1'b0;
      r_e1    <= 1'b0;
      r_v2    <= 1'b0;
      r_l2    <= 1'b0;
      r_e2    <= 1'b0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_first <= 1'b1;
    end else if (clr_addr) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_first <= 1'b1;
    end else if (!stall) begin
      r_v1   <= read_data;
      r_l1   <= co_pipe;
      r_e1   <= at_end_data & co_pipe;
      r_v2   <= r_v1;
      r_prod <= w_prod;
      r_l2   <= r_l1;
      r_e2   <= r_e1;
      if (r_v2) begin
        if (r_l2) begin
          r_first <= 1'b1;
        end else begin
          r_acc   <= w_sum;
          r_first <= 1'b0;
        end
      end
    end
  end

  psum_fifo #(
    .WIDTH      (PSUM_WIDTH + 1),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_psum_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     ({w_sum, r_e2}),
    .i_pop      (psum_ready),
    .o_data     (w_fifo_out),
    .o_count    (w_count),
    .o_empty    (w_empty),
    .o_overflow (err_overflow)
  );

  // Windows already closed in S1/S2 each claim a FIFO slot ahead of time
  assign w_credit = (FIFO_ADDR_WIDTH+2)'(w_count)
                  + (FIFO_ADDR_WIDTH+2)'(r_l1 & r_v1)
                  + (FIFO_ADDR_WIDTH+2)'(r_l2 & r_v2);

  assign stall_req  = (w_credit >= c_credit_limit);
  assign psum_valid = ~w_empty;
  assign psum_out   = w_fifo_out[PSUM_WIDTH:1];
  assign psum_last  = w_fifo_out[0];

endmodule
`default_nettype wire

// File: tb/tb_mac_psum_accumulator.sv
`default_nettype none
// ============================================================================
// tb_mac_psum_accumulator : directed + randomized bench with a psum queue model
// Revision: 1.0
// ============================================================================
module tb_mac_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, clr_addr, read_data, co_pipe, at_end_data, psum_ready;
  logic [7:0]  ifmap_data, filter_data;
  logic [19:0] psum_out;
  logic        psum_valid, psum_last, stall_req, err_overflow;

  typedef struct {
    logic [19:0] sum;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [19:0] model_sum;
  logic        data_due;
  int          pend_a, pend_b;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;

  mac_psum_accumulator u_dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .clr_addr     (clr_addr),
    .read_data    (read_data),
    .co_pipe      (co_pipe),
    .at_end_data  (at_end_data),
    .ifmap_data   (ifmap_data),
    .filter_data  (filter_data),
    .psum_ready   (psum_ready),
    .psum_out     (psum_out),
    .psum_valid   (psum_valid),
    .psum_last    (psum_last),
    .stall_req    (stall_req),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle, entered and left at a falling edge
  task automatic step(input logic rd, input logic co, input logic ae, input logic st,
                      input logic rdy, input logic clr, input int a, input int b);
    exp_t e;
    if (data_due) begin
      ifmap_data  = 8'(pend_a);
      filter_data = 8'(pend_b);
    end
    if (psum_valid && rdy) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("pop_value", 32'(psum_out), 32'(e.sum));
        chk("pop_last", 32'(psum_last), 32'(e.last));
      end
    end
    read_data   = rd;
    co_pipe     = co;
    at_end_data = ae;
    stall       = st;
    psum_ready  = rdy;
    clr_addr    = clr;
    data_due    = 1'b0;
    if (clr) begin
      model_sum = '0;
    end else if (rd && !st && rst) begin
      pend_a    = a;
      pend_b    = b;
      data_due  = 1'b1;
      model_sum = model_sum + 20'(a * b);
      if (co) begin
        e.sum  = model_sum;
        e.last = ae;
        exp_q.push_back(e);
        model_sum = '0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0, 0, 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_sum = '0;
    data_due  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic rd, st, rdy, co, ae, prev_sr;
    int   a, b, len, done, guard, pops0;

    rst = 1'b0; stall = 1'b0; clr_addr = 1'b0; read_data = 1'b0; co_pipe = 1'b0;
    at_end_data = 1'b0; psum_ready = 1'b0; ifmap_data = '0; filter_data = '0;
    model_clear();
    @(negedge clk);
    idle(1'b0);
    idle(1'b0);
    chk("rst_valid", 32'(psum_valid), 32'd0);
    chk("rst_last", 32'(psum_last), 32'd0);
    chk("rst_out", 32'(psum_out), 32'd0);
    chk("rst_stall_req", 32'(stall_req), 32'd0);
    chk("rst_overflow", 32'(err_overflow), 32'd0);
    rst = 1'b1;
    idle(1'b0);

    // Window of 3 and its latency
    step(1, 0, 0, 0, 1, 0, 2, 5);
    step(1, 0, 0, 0, 1, 0, -3, 6);
    step(1, 1, 0, 0, 1, 0, 4, -1);
    chk("lat_t1_valid", 32'(psum_valid), 32'd0);
    idle(1'b1);
    chk("lat_t2_valid", 32'(psum_valid), 32'd0);
    idle(1'b1);
    chk("lat_t3_valid", 32'(psum_valid), 32'd1);
    chk("win3_value", 32'(psum_out), 32'h000F_FFF4);
    chk("win3_last", 32'(psum_last), 32'd0);
    idle(1'b1);
    chk("win3_drained", 32'(psum_valid), 32'd0);

    // Windows of length 1, back to back
    for (int i = 0; i < 4; i++) step(1, 1, (i == 3), 0, 1, 0, i + 1, 2);
    chk("b2b_valid1", 32'(psum_valid), 32'd1);
    chk("b2b_out1", 32'(psum_out), 32'd4);
    chk("b2b_last1", 32'(psum_last), 32'd0);
    idle(1'b1);
    chk("b2b_out2", 32'(psum_out), 32'd6);
    idle(1'b1);
    chk("b2b_out3", 32'(psum_out), 32'd8);
    chk("b2b_last3", 32'(psum_last), 32'd1);
    idle(1'b1);
    chk("b2b_empty", 32'(psum_valid), 32'd0);

    // Fill with consumer blocked, controller honours stall_req one cycle late
    prev_sr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) chk("credit_before", 32'(stall_req), 32'd0);
      if (c == 3) chk("credit_rise", 32'(stall_req), 32'd1);
      rd      = ~prev_sr;
      prev_sr = stall_req;
      step(rd, 1, 0, 0, 0, 0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
    end
    chk("fill_overflow", 32'(err_overflow), 32'd0);
    chk("fill_valid", 32'(psum_valid), 32'd1);
    chk("fill_stall_req", 32'(stall_req), 32'd1);
    pops0 = n_pops;
    for (int c = 0; c < 8; c++) idle(1'b1);
    chk("fill_pops", 32'(n_pops - pops0), 32'd4);
    chk("fill_drained", 32'(psum_valid), 32'd0);
    chk("fill_credit_free", 32'(stall_req), 32'd0);

    // Accumulator wrap
    for (int i = 0; i < 40; i++) step(1, (i == 39), 0, 0, 0, 0, -128, -128);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("wrap40_valid", 32'(psum_valid), 32'd1);
    chk("wrap40_value", 32'(psum_out), 32'd655360);
    idle(1'b1);
    for (int i = 0; i < 100; i++) step(1, (i == 99), 0, 0, 0, 0, -128, -128);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("wrap100_value", 32'(psum_out), 32'd589824);
    idle(1'b1);

    // Abort mid-window; clr_addr beats a same-cycle read
    step(1, 0, 0, 0, 1, 0, 7, 3);
    step(1, 0, 0, 0, 1, 0, 5, 5);
    step(1, 0, 0, 0, 1, 1, 9, 9);
    step(1, 0, 0, 0, 1, 0, 1, 1);
    step(1, 1, 0, 0, 1, 0, 1, 1);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("clr_valid", 32'(psum_valid), 32'd1);
    chk("clr_value", 32'(psum_out), 32'd2);
    idle(1'b1);
    chk("clr_single", 32'(psum_valid), 32'd0);

    // Reset mid-window with two entries queued and stall held
    step(1, 1, 0, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0, 2, 2);
    idle(1'b0); idle(1'b0); idle(1'b0);
    step(1, 0, 0, 0, 0, 0, 5, 5);
    rst = 1'b0;
    step(0, 0, 0, 1, 0, 0, 0, 0);
    model_clear();
    chk("mrst_valid", 32'(psum_valid), 32'd0);
    chk("mrst_stall_req", 32'(stall_req), 32'd0);
    chk("mrst_out", 32'(psum_out), 32'd0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0, 0, 3, 4);
    step(1, 1, 0, 0, 0, 0, 2, -5);
    idle(1'b0); idle(1'b0); idle(1'b0);
    chk("mrst_value", 32'(psum_out), 32'd2);
    idle(1'b1);

    // Randomized windows with random stalls and consumer back-pressure
    prev_sr = 1'b0;
    for (int w = 0; w < 40; w++) begin
      len   = $urandom_range(1, 4);
      done  = 0;
      guard = 0;
      while (done < len && guard < 300) begin
        st  = ($urandom_range(0, 4) == 0);
        rdy = ($urandom_range(0, 9) < 6);
        rd  = ~prev_sr;
        prev_sr = stall_req;
        co  = (done == len - 1);
        ae  = co && (w == 39);
        a   = $urandom_range(0, 255) - 128;
        b   = $urandom_range(0, 255) - 128;
        if (rd && !st) done++;
        step(rd, co, ae, st, rdy, 0, a, b);
        guard++;
      end
      if (guard >= 300) chk("rand_progress", 32'(done), 32'(len));
    end
    for (int c = 0; c < 30 && (psum_valid || exp_q.size() != 0); c++) idle(1'b1);
    chk("rand_left", 32'(exp_q.size()), 32'd0);
    chk("rand_overflow", 32'(err_overflow), 32'd0);
    chk("rand_empty", 32'(psum_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_psum_accumulator.md
Name: mac_psum_accumulator

Overview:
- Downstream of the read address generator in the conv datapath.
- Receives IFMap/filter scratchpad read data one cycle after each issued read, and multiplies pairs in a registered stage.
- Accumulates one partial sum per window, delimited by co_pipe, into a small output FIFO.
- Generates stall_req back to the controller so the read side never outruns FIFO space.

Parameters:
- DATA_WIDTH, 8, signed width of IFMap and filter elements
- PSUM_WIDTH, 20, accumulator/output width (≥ 2*DATA_WIDTH)
- FIFO_DEPTH, 4, psum output FIFO entries (power of 2, ≥ 2)
- FIFO_ADDR_WIDTH, 2, log2(FIFO_DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset (clears state when 0 at a clk edge)
- stall  in  1  freezes compute stages, in lockstep with the address generator
- clr_addr  in  1  abort: flush in-flight reads and accumulator
- read_data  in  1  address generator issued a read this cycle
- co_pipe  in  1  issued read is the last element of the window
- at_end_data  in  1  issued read closes the final window of the layer
- ifmap_data  in  DATA_WIDTH  scratchpad output, valid 1 cycle after issue
- filter_data  in  DATA_WIDTH  scratchpad output, valid 1 cycle after issue
- psum_ready  in  1  consumer accepts head of FIFO
- psum_out  out  PSUM_WIDTH  FIFO head
- psum_valid  out  1  FIFO non-empty
- psum_last  out  1  head psum is the layer's final one
- stall_req  out  1  request controller stall (FIFO credit exhausted)
- err_overflow  out  1  sticky: push attempted while FIFO full

Behaviour:
- Reset (rst=0 at edge): all valid bits 0, accumulator 0, FIFO empty, err_overflow 0. Outputs: psum_valid=0, psum_last=0, psum_out=0, stall_req=0.
- Stage S1 (issue):
  - If ~stall: v1 <= read_data, l1 <= co_pipe, e1 <= at_end_data&co_pipe.
  - If stall: hold.
- Stage S2 (multiply):
  - If ~stall: v2 <= v1, prod <= signed(ifmap_data)*signed(filter_data) sign-extended to PSUM_WIDTH, l2 <= l1, e2 <= e1.
  - If stall: hold. Scratchpad addresses are held under stall, so data stays valid.
- Stage S3 (accumulate), when v2 & ~stall:
  - sum = (first ? 0 : acc) + prod, wrap modulo 2^PSUM_WIDTH, no saturation.
  - If l2: push {sum, e2} into FIFO, first <= 1.
  - Else: acc <= sum, first <= 0.
- Latency: last read issued at cycle t (unstalled) → psum_valid=1 in cycle t+3 when FIFO empty and no pop.
- Stall clears nothing; it only freezes S1–S3. The FIFO read side is independent of stall.
- clr_addr (~stall irrelevant): v1, v2 <= 0, first <= 1. FIFO contents retained. clr_addr wins over a same-cycle read_data.
- FIFO:
  - Pop when psum_valid & psum_ready.
  - Simultaneous push and pop: count unchanged, also when full.
  - Pop when empty: no-op.
  - Push when full with no pop: data dropped, err_overflow <= 1 (sticky until reset).
- Credit:
  - stall_req = (count + l1&v1 + l2&v2) ≥ FIFO_DEPTH−1. Computed combinationally from registers only; no dependence on stall.
  - Guarantees no overflow when the controller honours stall_req within 1 cycle.
- Window length 1 (co_pipe every read): one push per cycle sustained when psum_ready=1.
- Pointers wrap modulo FIFO_DEPTH. count width FIFO_ADDR_WIDTH+1.

Decomposition:
- Shared package/header: DATA_WIDTH, PSUM_WIDTH, FIFO_DEPTH, FIFO_ADDR_WIDTH defaults, shared with read_address_generator and top.
- One sub-module: psum_fifo (synchronous FIFO, WIDTH=PSUM_WIDTH+1, push/pop/count/full/empty, overflow flag).
- Stages and accumulator stay in the top module.

Test Plan:
- Window of 3, ifmap {2,−3,4}, filter {5,6,−1}, psum_ready=1 → single psum −12, psum_valid 3 cycles after the co_pipe read, psum_last=0.
- filter_size=1 back-to-back, 4 reads with ifmap=i+1, filter=2 → psums 2,4,6,8 on consecutive cycles; final one has psum_last=1 when at_end_data set.
- psum_ready=0, windows of 1 issued continuously while honouring stall_req → stall_req rises when count+in-flight=3, FIFO holds exactly 4, err_overflow=0. Then psum_ready=1 drains in order.
- Wrap: 40 reads of (−128)*(−128), PSUM_WIDTH=20 → result 655360 mod 2^20 = 655360. Then 100 reads → 1638400 mod 2^20 = 589824.
- clr_addr asserted after 2 of 3 reads, then new 2-element window {1*1,1*1} → only psum 2 emitted, no residue from aborted window.
- rst=0 mid-window with 2 FIFO entries and stall=1 → next cycle psum_valid=0, stall_req=0, subsequent window result correct from zero.
